// File: rtl/i2c_cmd_arbiter_pkg.sv
// rtl/i2c_cmd_arbiter_pkg.sv - shared types and constants for the I2C command arbiter
package i2c_cmd_arbiter_pkg;

  localparam int CMD_W = 16;
  localparam logic [CMD_W-1:0] WAIT_MARKER = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_WAIT_DLY  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_cmd_slot.sv
// rtl/i2c_cmd_slot.sv - single-entry pending command slot with drop detection
module i2c_cmd_slot
  import i2c_cmd_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_exec,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_clr,
  output logic             o_pending,
  output logic [CMD_W-1:0] o_data,
  output logic             o_drop
);

  logic             r_pending;
  logic [CMD_W-1:0] r_data;
  logic             w_accept;

  assign w_accept  = i_exec && !r_pending;
  assign o_drop    = i_exec && r_pending;
  assign o_pending = r_pending;
  assign o_data    = r_data;

  // Clear only ever targets an occupied slot, so it cannot coincide with an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_data    <= i_data;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - two-port fixed-priority arbiter in front of an I2C master
module i2c_cmd_arbiter
  import i2c_cmd_arbiter_pkg::*;
#(
  parameter logic [15:0] WAIT_CYCLES    = 16'd5000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_exec,
  input  logic [CMD_W-1:0] p0_data,
  output logic             p0_done,
  input  logic             p1_exec,
  input  logic [CMD_W-1:0] p1_data,
  output logic             p1_done,
  input  logic             cfg_done,
  output logic             i2c_exec,
  output logic [CMD_W-1:0] i2c_data,
  input  logic             i2c_done,
  output logic             busy,
  output logic [1:0]       err
);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic [15:0]      r_cnt;
  logic             r_gnt_p1;
  logic [CMD_W-1:0] r_i2c_data;
  logic             r_p0_done;
  logic             r_p1_done;
  logic [1:0]       r_err;

  logic             w_pend0, w_pend1;
  logic [CMD_W-1:0] w_slot0_data, w_slot1_data, w_gnt_data;
  logic             w_drop0, w_drop1;
  logic             w_gnt0, w_gnt1;
  logic             w_finish, w_timeout;
  logic             w_clr0, w_clr1;

  assign w_clr0 = w_finish && !r_gnt_p1;
  assign w_clr1 = w_finish && r_gnt_p1;

  i2c_cmd_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_exec    (p0_exec),
    .i_data    (p0_data),
    .i_clr     (w_clr0),
    .o_pending (w_pend0),
    .o_data    (w_slot0_data),
    .o_drop    (w_drop0)
  );

  i2c_cmd_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_exec    (p1_exec),
    .i_data    (p1_data),
    .i_clr     (w_clr1),
    .o_pending (w_pend1),
    .o_data    (w_slot1_data),
    .o_drop    (w_drop1)
  );

  assign w_gnt_data = w_gnt1 ? w_slot1_data : w_slot0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend0) begin
          w_gnt0       = 1'b1;
          w_next_state = (w_slot0_data == WAIT_MARKER) ? ST_WAIT_DLY : ST_ISSUE;
        end else if (w_pend1 && cfg_done) begin
          w_gnt1       = 1'b1;
          w_next_state = (w_slot1_data == WAIT_MARKER) ? ST_WAIT_DLY : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A completion arriving on the last allowed cycle wins over the timeout.
        if (i2c_done) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_cnt <= 16'd1) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_DLY: begin
        if (r_cnt <= 16'd1) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_gnt_p1   <= 1'b0;
      r_i2c_data <= '0;
      r_p0_done  <= 1'b0;
      r_p1_done  <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      r_p0_done <= w_finish && !r_gnt_p1;
      r_p1_done <= w_finish && r_gnt_p1;
      r_err     <= r_err | {w_timeout, w_drop0 || w_drop1};
      if (w_gnt0 || w_gnt1) begin
        r_i2c_data <= w_gnt_data;
        r_gnt_p1   <= w_gnt1;
        r_cnt      <= WAIT_CYCLES;
      end else if (r_state == ST_ISSUE) begin
        r_cnt <= TIMEOUT_CYCLES;
      end else if (w_finish) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_DONE || r_state == ST_WAIT_DLY) begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  assign i2c_exec = (r_state == ST_ISSUE);
  assign i2c_data = r_i2c_data;
  assign busy     = (r_state != ST_IDLE);
  assign p0_done  = r_p0_done;
  assign p1_done  = r_p1_done;
  assign err      = r_err;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - scoreboard bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;

  localparam logic [15:0] WCYC = 16'd100;
  localparam logic [15:0] TCYC = 16'd50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_exec = 1'b0, p1_exec = 1'b0, cfg_done = 1'b0, i2c_done = 1'b0;
  logic [15:0] p0_data = '0, p1_data = '0;
  logic        p0_done, p1_done, i2c_exec, busy;
  logic [15:0] i2c_data;
  logic [1:0]  err;

  i2c_cmd_arbiter #(.WAIT_CYCLES(WCYC), .TIMEOUT_CYCLES(TCYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_exec(p0_exec), .p0_data(p0_data), .p0_done(p0_done),
    .p1_exec(p1_exec), .p1_data(p1_data), .p1_done(p1_done),
    .cfg_done(cfg_done),
    .i2c_exec(i2c_exec), .i2c_data(i2c_data), .i2c_done(i2c_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: commands tracked by deadline cycle numbers.
  typedef struct { int c; logic [15:0] d; } ev_t;
  ev_t         q_issue[$];
  int          q_done0[$], q_done1[$];
  bit          m_pend [2];
  logic [15:0] m_dat  [2];
  bit          m_busy = 0, m_wait = 0, m_to = 0;
  int          m_port = 0, m_t_issue = 0, m_t_end = 0;
  logic [1:0]  m_err = 2'b00;
  bit          t_ex [2];
  logic [15:0] t_dx [2];
  bit          t_fin;
  int          t_g;
  ev_t         t_ev, mon_e;
  int          mon_c;

  initial begin
    m_pend[0] = 0; m_pend[1] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pend[0] = 0; m_pend[1] = 0; m_busy = 0; m_err = 2'b00;
        q_issue.delete(); q_done0.delete(); q_done1.delete();
      end else begin
        if (m_busy && !m_wait && i2c_done && cyc > m_t_issue && cyc < m_t_end) begin
          m_t_end = cyc + 1;
          m_to    = 0;
        end
        t_fin = m_busy && (cyc + 1 == m_t_end);
        t_g = -1;
        if (!m_busy) begin
          if (m_pend[0]) t_g = 0;
          else if (m_pend[1] && cfg_done) t_g = 1;
        end
        t_ex[0] = p0_exec; t_ex[1] = p1_exec; t_dx[0] = p0_data; t_dx[1] = p1_data;
        for (int p = 0; p < 2; p++) begin
          if (t_ex[p]) begin
            if (m_pend[p]) m_err[0] = 1'b1;
            else begin m_pend[p] = 1; m_dat[p] = t_dx[p]; end
          end
        end
        if (t_fin) begin
          m_pend[m_port] = 0;
          m_busy = 0;
          if (m_port == 0) q_done0.push_back(cyc + 1);
          else             q_done1.push_back(cyc + 1);
          if (!m_wait && m_to) m_err[1] = 1'b1;
        end
        if (t_g >= 0) begin
          m_busy = 1;
          m_port = t_g;
          m_wait = (m_dat[t_g] == 16'hFFFF);
          if (m_wait) m_t_end = cyc + 1 + int'(WCYC);
          else begin
            m_t_issue = cyc + 1;
            m_t_end   = cyc + 2 + int'(TCYC);
            m_to      = 1;
            t_ev.c = cyc + 1;
            t_ev.d = m_dat[t_g];
            q_issue.push_back(t_ev);
          end
        end
      end
      cyc++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", busy, m_busy);
        chk("err", err, m_err);
        if (i2c_exec) begin
          if (q_issue.size() == 0) chk("unexpected_i2c_exec", i2c_data, 32'hDEAD_BEEF);
          else begin
            mon_e = q_issue.pop_front();
            chk("i2c_exec_cycle", cyc, mon_e.c);
            chk("i2c_data", i2c_data, mon_e.d);
          end
        end
        if (p0_done) begin
          if (q_done0.size() == 0) chk("unexpected_p0_done", cyc, 32'hFFFF_FFFF);
          else begin mon_c = q_done0.pop_front(); chk("p0_done_cycle", cyc, mon_c); end
        end
        if (p1_done) begin
          if (q_done1.size() == 0) chk("unexpected_p1_done", cyc, 32'hFFFF_FFFF);
          else begin mon_c = q_done1.pop_front(); chk("p1_done_cycle", cyc, mon_c); end
        end
      end
    end
  end

  // I2C master stand-in: answers after resp_delay cycles (0 = never), plus optional noise.
  int resp_delay = 40;
  int done_at = -1;
  bit spur_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && i2c_exec) done_at = (resp_delay > 0) ? cyc + resp_delay : -1;
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i2c_done = rst_n && ((cyc == done_at) || (spur_en && $urandom_range(0, 15) == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [15:0] d);
    if (p == 0) begin p0_exec = 1'b1; p0_data = d; end
    else        begin p1_exec = 1'b1; p1_data = d; end
    tick();
    p0_exec = 1'b0;
    p1_exec = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((m_busy || m_pend[0] || m_pend[1]) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (n < maxc), 1);
    tick();
    tick();
    chk("leftover_events", q_issue.size() + q_done0.size() + q_done1.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_i2c_exec"}, i2c_exec, 0);
    chk({tag, "_i2c_data"}, i2c_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_p0_done"}, p0_done, 0);
    chk({tag, "_p1_done"}, p1_done, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single command, master answers after 40 cycles.
    resp_delay = 40;
    send(0, 16'h0016);
    drain(200);

    // Port 1 held off until cfg_done rises.
    send(1, 16'h301A);
    repeat (20) tick();
    chk("p1_blocked_busy", busy, 0);
    cfg_done = 1'b1;
    drain(200);

    // Simultaneous requests: port 0 first.
    resp_delay = 7;
    p0_exec = 1'b1; p0_data = 16'h2E1A;
    p1_exec = 1'b1; p1_data = 16'h2F1A;
    tick();
    p0_exec = 1'b0; p1_exec = 1'b0;
    drain(300);

    // Wait marker.
    send(0, 16'hFFFF);
    drain(300);

    // Timeout, then drop while pending.
    resp_delay = 0;
    send(0, 16'h1234);
    drain(200);
    chk("err_after_timeout", err, 2'b10);
    send(0, 16'h5678);
    send(0, 16'h9ABC);
    drain(200);
    chk("err_after_drop", err, 2'b11);

    // Reset while waiting for the master.
    send(0, 16'h4242);
    repeat (10) tick();
    chk("in_wait_done_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (80) tick();
    chk("post_reset_leftover", q_issue.size() + q_done0.size() + q_done1.size(), 0);

    // Randomized traffic with noisy i2c_done and toggling cfg_done.
    spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      resp_delay = $urandom_range(0, 60);
      p0_exec = ($urandom_range(0, 9) == 0);
      p1_exec = ($urandom_range(0, 11) == 0);
      p0_data = ($urandom_range(0, 24) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      p1_data = ($urandom_range(0, 24) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      if ($urandom_range(0, 39) == 0) cfg_done = ~cfg_done;
      tick();
    end
    p0_exec = 1'b0;
    p1_exec = 1'b0;
    cfg_done = 1'b1;
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
